// File: rtl/m_arbiter_link_pkg.sv
// Shared definitions for the master side of the serial arbitration link:
// frame opcodes, arbiter response codes, link FSM states and frame sizing.
package m_arbiter_link_pkg;

  // Master-to-arbiter opcodes (00 and 11 are never transmitted)
  localparam logic [1:0] OP_REQ  = 2'b01;
  localparam logic [1:0] OP_DONE = 2'b10;

  // Arbiter-to-master responses (00 and 11 are discarded)
  localparam logic [1:0] RSP_GRANT = 2'b01;
  localparam logic [1:0] RSP_SPLIT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_REQ,
    ST_WAIT_GRANT,
    ST_OWN,
    ST_TX_DONE
  } link_state_e;

  // Master frame: start bit, 2-bit opcode, then the slave id bits
  function automatic int frame_len(input int id_width);
    return 3 + id_width;
  endfunction

endpackage

// File: rtl/m_link_rx.sv
// Receiver for arbiter-to-master frames: detects the start bit, shifts in
// the two response bits and presents the code with a one-cycle valid.
// It is ready for the next start bit on the cycle the valid is shown,
// so back-to-back arbiter frames are accepted.
module m_link_rx (
  input  logic       clk,
  input  logic       rstN,
  input  logic       arb_in,
  output logic       rx_valid,
  output logic [1:0] rx_code
);

  logic [1:0] phase_q;
  logic       first_q;

  // Phase 0 hunts for a start bit, phases 1 and 2 capture the response bits
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      phase_q  <= 2'd0;
      first_q  <= 1'b0;
      rx_valid <= 1'b0;
      rx_code  <= 2'b00;
    end else begin
      rx_valid <= 1'b0;
      case (phase_q)
        2'd0: begin
          if (arb_in) phase_q <= 2'd1;
        end
        2'd1: begin
          first_q <= arb_in;
          phase_q <= 2'd2;
        end
        2'd2: begin
          rx_code  <= {first_q, arb_in};
          rx_valid <= 1'b1;
          phase_q  <= 2'd0;
        end
        default: phase_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/m_arbiter_link.sv
// Master-side endpoint of the serial arbitration link. Turns a level
// request plus slave id into a REQ frame, waits for the arbiter's GRANT,
// tracks SPLIT while owning the bus and sends a DONE frame on release.
module m_arbiter_link
  import m_arbiter_link_pkg::*;
#(
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req,
  input  logic [S_ID_WIDTH-1:0] slave_id,
  input  logic                  done,
  output logic                  granted,
  output logic                  split,
  output logic                  link_busy,
  input  logic                  arb_in,
  output logic                  arb_out
);

  localparam int FRAME_LEN = frame_len(S_ID_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  link_state_e           state_q;
  link_state_e           state_d;
  logic [S_ID_WIDTH-1:0] id_q;
  logic [FRAME_LEN-1:0]  tx_shift_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic                  arb_out_q;
  logic                  split_q;
  logic                  load_req;
  logic                  load_done;
  logic                  in_tx;
  logic                  tx_last;
  logic                  rx_valid;
  logic [1:0]            rx_code;
  logic                  rsp_grant;
  logic                  rsp_split;
  logic [FRAME_LEN-1:0]  req_frame;
  logic [FRAME_LEN-1:0]  done_frame;

  m_link_rx u_rx (
    .clk      (clk),
    .rstN     (rstN),
    .arb_in   (arb_in),
    .rx_valid (rx_valid),
    .rx_code  (rx_code)
  );

  assign rsp_grant  = rx_valid && (rx_code == RSP_GRANT);
  assign rsp_split  = rx_valid && (rx_code == RSP_SPLIT);
  assign in_tx      = (state_q == ST_TX_REQ) || (state_q == ST_TX_DONE);
  assign tx_last    = (tx_cnt_q == LAST_CNT);
  assign req_frame  = {1'b1, OP_REQ, slave_id};
  assign done_frame = {1'b1, OP_DONE, id_q};

  assign granted   = (state_q == ST_OWN);
  assign split     = split_q;
  assign link_busy = (state_q != ST_IDLE);
  assign arb_out   = arb_out_q;

  // Next-state logic; a TX state hands over once every frame bit has been shown
  always_comb begin
    state_d   = state_q;
    load_req  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && (slave_id != '0)) begin
          state_d  = ST_TX_REQ;
          load_req = 1'b1;
        end
      end
      ST_TX_REQ: begin
        if (tx_last) state_d = ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        if (rsp_grant) state_d = ST_OWN;
      end
      ST_OWN: begin
        if (done) begin
          state_d   = ST_TX_DONE;
          load_done = 1'b1;
        end
      end
      ST_TX_DONE: begin
        if (tx_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Frame shifter: load on entry to a TX state, then emit MSB first, one bit per cycle
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      id_q       <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      arb_out_q  <= 1'b0;
    end else if (load_req) begin
      id_q       <= slave_id;
      tx_shift_q <= req_frame;
      tx_cnt_q   <= '0;
      arb_out_q  <= 1'b0;
    end else if (load_done) begin
      tx_shift_q <= done_frame;
      tx_cnt_q   <= '0;
      arb_out_q  <= 1'b0;
    end else if (in_tx && !tx_last) begin
      arb_out_q  <= tx_shift_q[FRAME_LEN-1];
      tx_shift_q <= {tx_shift_q[FRAME_LEN-2:0], 1'b0};
      tx_cnt_q   <= tx_cnt_q + CNT_W'(1);
    end else begin
      arb_out_q  <= 1'b0;
    end
  end

  // Sticky split flag, only meaningful in OWN; a simultaneous done takes priority
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      split_q <= 1'b0;
    end else if (state_q == ST_OWN) begin
      if (done)           split_q <= 1'b0;
      else if (rsp_split) split_q <= 1'b1;
    end else begin
      split_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_arbiter_link.sv
// Self-checking bench for m_arbiter_link: a driver plays the bus master and
// the arbiter, pushing each master frame it expects into a queue; a monitor
// decodes arb_out independently and compares every frame it sees.
module tb_m_arbiter_link;
  import m_arbiter_link_pkg::*;

  localparam int ID_W = 2;
  localparam int LEN  = 5;

  logic            clk      = 1'b0;
  logic            rstN     = 1'b0;
  logic            req      = 1'b0;
  logic            done     = 1'b0;
  logic            arb_in   = 1'b0;
  logic [ID_W-1:0] slave_id = '0;
  logic            granted;
  logic            split;
  logic            link_busy;
  logic            arb_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]      op;
    logic [ID_W-1:0] id;
    int              start;
  } frame_t;

  frame_t exp_q[$];

  logic           mon_in_frame = 1'b0;
  logic           mon_trail    = 1'b0;
  int             mon_nb       = 0;
  int             mon_start    = 0;
  logic [LEN-1:0] mon_bits     = '0;

  m_arbiter_link #(.NO_SLAVES(3), .S_ID_WIDTH(ID_W)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .req       (req),
    .slave_id  (slave_id),
    .done      (done),
    .granted   (granted),
    .split     (split),
    .link_busy (link_busy),
    .arb_in    (arb_in),
    .arb_out   (arb_out)
  );

  // Free-running clock and edge counter used to time expected frame starts
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_status(input string name, input logic g, input logic s, input logic b);
    check_output({name, ".granted"}, int'(granted), int'(g));
    check_output({name, ".split"}, int'(split), int'(s));
    check_output({name, ".link_busy"}, int'(link_busy), int'(b));
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Arbiter response frame: start bit then two code bits, MSB first
  task automatic send_rsp(input logic [1:0] code);
    arb_in = 1'b1;
    step();
    arb_in = code[1];
    step();
    arb_in = code[0];
    step();
    arb_in = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [ID_W-1:0] id, input bit idle_junk, input bit tx_grant,
                                input bit wait_junk, input int hold, input int mode);
    int e0;
    logic [1:0] junk;
    if (idle_junk) begin
      send_rsp(RSP_GRANT);
      step();
      check_status("idle_grant", 1'b0, 1'b0, 1'b0);
      slave_id = '0;
      req = 1'b1;
      step();
      req = 1'b0;
      check_status("id0_ignored", 1'b0, 1'b0, 1'b0);
    end
    slave_id = id;
    req = 1'b1;
    exp_q.push_back('{op: OP_REQ, id: id, start: cyc + 2});
    step();
    req = 1'b0;
    slave_id = ID_W'($urandom_range(0, 3));
    e0 = cyc;
    check_status("req_busy", 1'b0, 1'b0, 1'b1);
    if (tx_grant) begin
      send_rsp(RSP_GRANT);
      step();
      check_status("tx_grant_dropped", 1'b0, 1'b0, 1'b1);
    end
    while (cyc < e0 + 6) step();
    check_output("wait_arb_out_low", int'(arb_out), 0);
    if (wait_junk) begin
      send_rsp(RSP_SPLIT);
      step();
      check_status("wait_split_dropped", 1'b0, 1'b0, 1'b1);
      done = 1'b1;
      step();
      done = 1'b0;
      check_status("wait_done_ignored", 1'b0, 1'b0, 1'b1);
    end
    send_rsp(RSP_GRANT);
    check_output("grant_not_early", int'(granted), 0);
    step();
    check_status("grant", 1'b1, 1'b0, 1'b1);
    step(hold);
    check_status("own_hold", 1'b1, 1'b0, 1'b1);
    case (mode)
      1: begin
        junk = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00;
        send_rsp(junk);
        step();
        check_status("own_junk", 1'b1, 1'b0, 1'b1);
      end
      2: begin
        send_rsp(RSP_SPLIT);
        check_output("split_not_early", int'(split), 0);
        step();
        check_status("split", 1'b1, 1'b1, 1'b1);
        step($urandom_range(1, 5));
        check_status("split_sticky", 1'b1, 1'b1, 1'b1);
      end
      3: begin
        send_rsp(RSP_SPLIT);
      end
      default: ;
    endcase
    done = 1'b1;
    exp_q.push_back('{op: OP_DONE, id: id, start: cyc + 2});
    step();
    done = 1'b0;
    check_status("done_release", 1'b0, 1'b0, 1'b1);
    step(7);
    check_status("back_idle", 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: rebuild each master frame from arb_out and score it against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rstN) begin
        mon_in_frame = 1'b0;
        mon_trail    = 1'b0;
        continue;
      end
      if (mon_trail) begin
        check_output("frame_trail_low", int'(arb_out), 0);
        mon_trail = 1'b0;
      end else if (!mon_in_frame) begin
        if (arb_out) begin
          mon_in_frame = 1'b1;
          mon_nb       = 1;
          mon_bits     = LEN'(1);
          mon_start    = cyc;
        end
      end else begin
        mon_bits = {mon_bits[LEN-2:0], arb_out};
        mon_nb++;
        if (mon_nb == LEN) begin
          mon_in_frame = 1'b0;
          mon_trail    = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got %b expected no frame", mon_bits);
          end else begin
            frame_t e;
            e = exp_q.pop_front();
            check_output("frame_bits", int'(mon_bits), int'({1'b1, e.op, e.id}));
            check_output("frame_start", mon_start, e.start);
          end
        end
      end
    end
  end

  // Main sequence: reset, directed scenarios, randomized transactions, reset mid-frame
  initial begin
    step();
    check_status("reset", 1'b0, 1'b0, 1'b0);
    check_output("reset_arb_out", int'(arb_out), 0);
    step();
    rstN = 1'b1;
    step(2);
    check_status("post_reset_idle", 1'b0, 1'b0, 1'b0);

    apply_stimulus(2'd2, 1'b0, 1'b0, 1'b0, 20, 2);
    apply_stimulus(2'd2, 1'b1, 1'b1, 1'b1, 3, 3);
    apply_stimulus(2'd1, 1'b0, 1'b0, 1'b0, 2, 1);

    for (int i = 0; i < 30; i++) begin
      apply_stimulus(ID_W'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), $urandom_range(1, 20), $urandom_range(0, 3));
      step($urandom_range(0, 3));
    end

    slave_id = 2'd1;
    req = 1'b1;
    step();
    req = 1'b0;
    step(3);
    check_output("pre_reset_arb_out", int'(arb_out), 1);
    #2 rstN = 1'b0;
    #1;
    check_status("async_reset", 1'b0, 1'b0, 1'b0);
    check_output("async_reset_arb_out", int'(arb_out), 0);
    step(2);
    rstN = 1'b1;
    step(2);
    check_status("after_reset_idle", 1'b0, 1'b0, 1'b0);
    apply_stimulus(2'd3, 1'b0, 1'b0, 1'b0, 4, 0);

    step(4);
    check_output("frames_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/m_arbiter_link.md
# m_arbiter_link

Master-side endpoint of the serial arbitration link: sits inside each bus master and talks to that master's dedicated port on the central arbiter over a one-wire-each-way serial pair. Converts a local level request plus target slave id into a serial REQ frame, decodes the arbiter's serial GRANT/SPLIT responses, and serialises a DONE frame when the master core releases the bus. The bus multiplexers are steered by the arbiter; this block only negotiates ownership.

## Interface
- NO_SLAVES, 3, number of slaves on the bus
- S_ID_WIDTH, $clog2(NO_SLAVES+1), slave id width; id 0 is reserved as "no slave"

- clk  input  1  single clock; all logic on rising edge
- rstN  input  1  asynchronous, active-low reset
- req  input  1  level: master core wants the bus; sampled only in IDLE
- slave_id  input  S_ID_WIDTH  target slave; latched with req
- done  input  1  one-cycle pulse: master finished, release the bus; honoured only in OWN
- granted  output  1  bus owned by this master
- split  output  1  arbiter demands early release; sticky until DONE is sent
- link_busy  output  1  high in every state except IDLE
- arb_in  input  1  serial line from the arbiter port (arbiter's port_out)
- arb_out  output  1  serial line to the arbiter port (arbiter's port_in), registered

## Operation
- Line format, both directions: idle low, one bit per clk, MSB first, start bit = 1.
- Master→arbiter frame: start, 2-bit opcode, S_ID_WIDTH id bits (3+S_ID_WIDTH bits). Opcodes: 01 REQ, 10 DONE; 00/11 never sent.
- Arbiter→master frame: start, 2-bit response. 01 GRANT, 10 SPLIT; 00/11 discarded.
- States: IDLE, TX_REQ, WAIT_GRANT, OWN, TX_DONE.
- IDLE: arb_out=0. req=1 and slave_id≠0 → latch id, go TX_REQ. req with slave_id=0 ignored.
- TX_REQ: shift out REQ frame; after last bit → WAIT_GRANT. req/slave_id changes ignored; request cannot be withdrawn.
- WAIT_GRANT: decoded GRANT → OWN. SPLIT ignored.
- OWN: granted=1. Decoded SPLIT → split=1. done → TX_DONE; granted and split clear on that edge.
- TX_DONE: shift out DONE frame with latched id; after last bit → IDLE.
- Decoded frames outside the above cases (GRANT in IDLE/OWN/TX_*, SPLIT outside OWN) are dropped silently.
- done and a decoded SPLIT on the same edge in OWN: done wins, split stays 0.
- Reset (any time, incl. mid-frame): state IDLE, arb_out=0, granted=0, split=0, link_busy=0, receiver shift state cleared. A partial frame is simply truncated; the arbiter side resynchronises on its own reset.

## Timing
- req sampled high at edge 0 → start bit on arb_out after edge 1; last id bit after edge 3+S_ID_WIDTH; arb_out low again after edge 4+S_ID_WIDTH.
- Receiver: start sampled at edge k, response bits at k+1, k+2; decoded result acts at edge k+3 (granted/split rise after edge k+3).
- Receiver is ready for a new start bit at edge k+3; back-to-back arbiter frames supported.
- IDLE lasts at least one cycle between DONE and the next REQ, guaranteeing ≥1 low bit between master frames.
- done → granted low after the same edge; DONE start bit after the next edge.
- Receiver runs in every state, including while transmitting.

## Structure
- Shared package (arbiter link package): opcode constants REQ/DONE, response constants GRANT/SPLIT, state enum, frame-length helper.
- One sub-module: m_link_rx (start detect + 2-bit shift + one-cycle decoded valid/code outputs). TX shifter and FSM stay in the top.

## Test plan
- S_ID_WIDTH=2, req=1, slave_id=2 → arb_out = 1,0,1,1,0 on cycles 1–5, then 0; link_busy=1 from edge 0.
- In WAIT_GRANT drive arb_in 1,0,1 → granted=1 three edges after start; hold 20 cycles stable.
- In OWN drive SPLIT (1,1,0) → split=1; pulse done → granted=0, split=0, arb_out = 1,1,0,1,0 (DONE, id 2), then IDLE.
- SPLIT decode coincident with done → split never rises; DONE frame still sent.
- GRANT in IDLE, SPLIT in WAIT_GRANT, code 11 in OWN → no output change.
- rstN low at cycle 3 of TX_REQ → all outputs 0 asynchronously; after release, new req sends a full frame from start bit.
